adc_sample_averager: RTL

- Downstream consumer of the sample-rate clock (nominally 100 kHz, generated in the adc_clk domain from the 125 MHz ADC clock).
- Detects each rising edge of sample_clock and captures one signed ADC word.
- Averages blocks of 2^AVG_LOG2 samples and presents each average on a valid/ready stream toward the processing/DMA stage.
- Flags results dropped because the consumer stalled.

---
 rtl/adc_sample_averager_if.sv | 11 +
 rtl/adc_sample_averager.sv | 122 ++++++++++++
 2 files changed

// File: rtl/adc_sample_averager_if.sv
// Averaged-sample output stream: valid/ready handshake carrying one signed word.
interface adc_sample_averager_if #(
    parameter int unsigned DATA_W = 14
) ();
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/adc_sample_averager.sv
// Averages 2^AVG_LOG2 ADC words, one per sample_clock rising edge, onto a valid/ready stream.
// Optional ADC_AVG_ROUND_EN: round half toward +inf instead of floor.
module adc_sample_averager #(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned AVG_LOG2 = 2
) (
    input  logic                     adc_clk,
    input  logic                     adc_rst,
    input  logic                     sample_clock,
    input  logic signed [DATA_W-1:0] adc_data,
    input  logic                     enable,
    adc_sample_averager_if.master    m,
    output logic                     overflow
);
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sc_d;
    logic [DATA_W-1:0]         data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ovf_q, ovf_d;

    logic                      tick_c;
    logic                      last_c;
    logic                      done_c;
    logic signed [SUM_W-1:0]   sum_c;
    logic signed [SUM_W-1:0]   sum_r_c;
    logic [DATA_W-1:0]         avg_c;

    assign tick_c = sample_clock & ~sc_d;
    assign last_c = (cnt_q == CNT_LAST);
    assign sum_c  = SUM_W'(acc_q) + SUM_W'(adc_data);

`ifdef ADC_AVG_ROUND_EN
    localparam int unsigned RND = (1 << AVG_LOG2) >> 1;
    // Extra sum bit keeps the rounding bias from wrapping at the positive extreme.
    assign sum_r_c = sum_c + SUM_W'(RND);
`else
    assign sum_r_c = sum_c;
`endif

    assign avg_c = DATA_W'(sum_r_c >>> AVG_LOG2);

    // Next-state, accumulator and output-stream decisions.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        done_c  = 1'b0;

        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable) state_d = ACCUM;
            end
            ACCUM: begin
                if (!enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (tick_c) begin
                    if (last_c) begin
                        done_c = 1'b1;
                        acc_d  = '0;
                        cnt_d  = '0;
                    end else begin
                        acc_d = ACC_W'(sum_c);
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new result wins over a transfer; with the slot full and stalled it is dropped.
        if (done_c) begin
            if (!valid_q || m.m_ready) begin
                data_d  = avg_c;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && m.m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sc_d    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sc_d    <= sample_clock;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign m.m_data  = data_q;
    assign m.m_valid = valid_q;
    assign overflow  = ovf_q;
endmodule
